seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector. It generalises the fixed "two consecutive 1s" FSM detector to a run-time programmable pattern of PAT_LEN bits. It also adds selectable overlapping or non-overlapping detection, both Mealy and Moore match outputs, and a saturating match counter. It sits on a serial bit stream qualified by a valid strobe and feeds status/interrupt logic.

---
 rtl/seq_pattern_detector.sv | 110 +++++++++++
 tb/tb_seq_pattern_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial bit-pattern detector with a run-time programmable
// PAT_LEN-bit pattern, overlapping or non-overlapping matching, a combinational
// (Mealy) match, a registered (Moore) match and a saturating match counter.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   in_valid, in_bit   serial bit stream, one bit consumed per valid edge
//   cfg_we, cfg_pat,   load a new pattern and overlap mode; restarts matching
//   cfg_ovl
//   clear_cnt          synchronous clear of match_cnt (wins over a match)
//   match              high in the same cycle as the bit completing the pattern
//   match_q            match delayed by one clock
//   match_cnt          saturating number of matches
//   progress           pattern prefix length currently matched (0..PAT_LEN-1)
module seq_pattern_detector #(
    parameter int                 PAT_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
    parameter logic               DEFAULT_OVL = 1'b1,
    localparam int                PW          = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pat,
    input  logic               cfg_ovl,
    input  logic               clear_cnt,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [PW-1:0]      progress
);

    if (PAT_LEN < 2 || PAT_LEN > 8) begin : g_bad_pat_len
        $error("seq_pattern_detector: PAT_LEN must be in 2..8");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("seq_pattern_detector: CNT_W must be in 1..16");
    end

    localparam logic [PW-1:0]    HCNT_MAX = PW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] pat;
    logic               ovl;
    logic [PAT_LEN-2:0] hist;   // newest received bit in bit 0
    logic [PW-1:0]      hcnt;   // how many bits of hist are meaningful
    logic [PAT_LEN-1:0] word;   // history plus the bit on the wire right now

    assign word  = {hist, in_bit};
    // hcnt == PAT_LEN-1 guarantees a full window; it is forced to 0 by reset
    // and cfg_we, which keeps match low in both situations.
    assign match = in_valid & ~cfg_we & (hcnt == HCNT_MAX) & (word == pat);

    // Longest prefix of the pattern that ends the current history, limited to
    // the bits actually collected since the last restart.
    logic prefix_ok;
    always_comb begin
        progress  = '0;
        prefix_ok = 1'b0;
        for (int k = 1; k < PAT_LEN; k++) begin
            prefix_ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (hist[k-1-i] != pat[PAT_LEN-1-i]) begin
                    prefix_ok = 1'b0;
                end
            end
            if (prefix_ok && (PW'(k) <= hcnt)) begin
                progress = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat       <= DEFAULT_PAT;
            ovl       <= DEFAULT_OVL;
            hist      <= '0;
            hcnt      <= '0;
            match_q   <= 1'b0;
            match_cnt <= '0;
        end else begin
            match_q <= match;

            if (clear_cnt) begin
                match_cnt <= '0;
            end else if (match && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end

            // A configuration write drops any bit offered in the same cycle.
            if (cfg_we) begin
                pat  <= cfg_pat;
                ovl  <= cfg_ovl;
                hcnt <= '0;
            end else if (in_valid) begin
                hist <= word[PAT_LEN-2:0];
                if (match && !ovl) begin
                    // Non-overlapping: the completing bits are not reused.
                    hcnt <= '0;
                end else if (hcnt != HCNT_MAX) begin
                    hcnt <= hcnt + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: PAT_LEN 4, CNT_W 8, defaults 1011 / overlap.
    logic       a_valid = 0, a_bit = 0, a_we = 0, a_ovl = 0, a_clr = 0;
    logic [3:0] a_pat = '0;
    logic       a_match, a_match_q;
    logic [7:0] a_cnt;
    logic [2:0] a_prog;

    // Instance B: PAT_LEN 2, CNT_W 2, defaults 11 / overlap.
    logic       b_valid = 0, b_bit = 0, b_we = 0, b_ovl = 0, b_clr = 0;
    logic [1:0] b_pat = '0;
    logic       b_match, b_match_q;
    logic [1:0] b_cnt;
    logic [1:0] b_prog;

    seq_pattern_detector #(
        .PAT_LEN(4), .CNT_W(8), .DEFAULT_PAT(4'b1011), .DEFAULT_OVL(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_bit(a_bit),
        .cfg_we(a_we), .cfg_pat(a_pat), .cfg_ovl(a_ovl), .clear_cnt(a_clr),
        .match(a_match), .match_q(a_match_q), .match_cnt(a_cnt), .progress(a_prog)
    );

    seq_pattern_detector #(
        .PAT_LEN(2), .CNT_W(2), .DEFAULT_PAT(2'b11), .DEFAULT_OVL(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_bit(b_bit),
        .cfg_we(b_we), .cfg_pat(b_pat), .cfg_ovl(b_ovl), .clear_cnt(b_clr),
        .match(b_match), .match_q(b_match_q), .match_cnt(b_cnt), .progress(b_prog)
    );

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Reference model: the bit stream received since the last restart, kept as
    // a plain list (oldest first), plus the configured pattern and counter.
    int       cur = 0;      // which instance is being exercised
    int       m_plen;
    bit [7:0] m_pat;
    bit       m_ovl;
    int       m_cnt;
    int       m_max;
    bit       mq[$];

    function automatic bit pat_bit(int i);   // i = 0 is the first bit on the wire
        return m_pat[m_plen-1-i];
    endfunction

    function automatic bit exp_match(bit v, bit b, bit we);
        if (!v || we || mq.size() < m_plen - 1) return 1'b0;
        for (int i = 0; i < m_plen - 1; i++)
            if (mq[mq.size() - (m_plen - 1) + i] != pat_bit(i)) return 1'b0;
        return b == pat_bit(m_plen - 1);
    endfunction

    function automatic int exp_prog();
        int n;
        bit ok;
        n = (mq.size() < m_plen - 1) ? mq.size() : m_plen - 1;
        for (int k = n; k >= 1; k--) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++)
                if (mq[mq.size() - k + i] != pat_bit(i)) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    function automatic logic [15:0] obs_match();
        return cur == 1 ? 16'(b_match) : 16'(a_match);
    endfunction
    function automatic logic [15:0] obs_match_q();
        return cur == 1 ? 16'(b_match_q) : 16'(a_match_q);
    endfunction
    function automatic logic [15:0] obs_cnt();
        return cur == 1 ? 16'(b_cnt) : 16'(a_cnt);
    endfunction
    function automatic logic [15:0] obs_prog();
        return cur == 1 ? 16'(b_prog) : 16'(a_prog);
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic drive(bit v, bit b, bit we, bit [7:0] cp, bit co, bit clr);
        if (cur == 1) begin
            b_valid = v; b_bit = b; b_we = we; b_pat = cp[1:0]; b_ovl = co; b_clr = clr;
        end else begin
            a_valid = v; a_bit = b; a_we = we; a_pat = cp[3:0]; a_ovl = co; a_clr = clr;
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(bit v, bit b, bit we, bit [7:0] cp, bit co, bit clr, string tag);
        bit em;
        int ep;
        step_no++;
        drive(v, b, we, cp, co, clr);
        em = exp_match(v, b, we);
        ep = exp_prog();
        @(negedge clk);
        check({tag, ".match"}, obs_match(), 16'(em));
        check({tag, ".prog_pre"}, obs_prog(), 16'(ep));
        @(posedge clk);
        #1;
        if (clr) m_cnt = 0;
        else if (em && m_cnt < m_max) m_cnt++;
        if (we) begin
            m_pat = cp;
            m_ovl = co;
            mq.delete();
        end else if (v) begin
            if (em && !m_ovl) mq.delete();
            else begin
                mq.push_back(b);
                if (mq.size() > 16) void'(mq.pop_front());
            end
        end
        check({tag, ".match_q"}, obs_match_q(), 16'(em));
        check({tag, ".cnt"}, obs_cnt(), 16'(m_cnt));
        check({tag, ".prog"}, obs_prog(), 16'(exp_prog()));
    endtask

    task automatic bits(bit [15:0] pattern, int n, string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b1, pattern[i], 1'b0, 8'd0, 1'b0, 1'b0, tag);
    endtask

    // Reset raised between clock edges with the current inputs still applied.
    task automatic rst_pulse(string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, ".rst_match"},   obs_match(),   16'd0);
        check({tag, ".rst_match_q"}, obs_match_q(), 16'd0);
        check({tag, ".rst_cnt"},     obs_cnt(),     16'd0);
        check({tag, ".rst_prog"},    obs_prog(),    16'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_plen = (cur == 1) ? 2 : 4;
        m_max  = (cur == 1) ? 3 : 255;
        m_pat  = (cur == 1) ? 8'b11 : 8'b1011;
        m_ovl  = 1'b1;
        m_cnt  = 0;
        mq.delete();
    endtask

    task automatic select(int d, string tag);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        cur = d;
        rst_pulse(tag);
    endtask

    initial begin
        // Power-on reset of instance A.
        cur = 0;
        select(0, "por");

        // Default 1011 overlap: matches on bits 4 and 7.
        bits(16'b1011011, 7, "ovl");
        check("ovl.total", obs_cnt(), 16'd2);

        // Non-overlap: only bit 4 matches.
        select(0, "novl");
        step(1'b0, 1'b0, 1'b1, 8'b1011, 1'b0, 1'b0, "novl.cfg");
        bits(16'b1011011, 7, "novl");
        check("novl.total", obs_cnt(), 16'd1);

        // Reconfigure mid-stream; the bit offered with cfg_we is dropped.
        select(0, "recfg");
        bits(16'b101, 3, "recfg.pre");
        step(1'b1, 1'b1, 1'b1, 8'b0110, 1'b1, 1'b0, "recfg.we");
        check("recfg.prog0", obs_prog(), 16'd0);
        bits(16'b0110, 4, "recfg.post");
        check("recfg.total", obs_cnt(), 16'd1);

        // Asynchronous reset mid-pattern with a completing bit on the wire.
        select(0, "arst");
        bits(16'b101, 3, "arst.pre");
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        rst_pulse("arst");
        bits(16'b11, 2, "arst.post1");
        check("arst.nomatch", obs_cnt(), 16'd0);
        bits(16'b011, 3, "arst.post2");
        check("arst.total", obs_cnt(), 16'd1);

        // Instance B: pattern 11 overlap.
        select(1, "p2");
        bits(16'b011101, 6, "p2");
        check("p2.total", obs_cnt(), 16'd2);

        // Same stream with idle cycles between bits.
        select(1, "gap");
        for (int i = 5; i >= 0; i--) begin
            bit [15:0] s;
            s = 16'b011101;
            step(1'b1, s[i], 1'b0, 8'd0, 1'b0, 1'b0, "gap.v");
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'd0, 1'b0, 1'b0, "gap.idle");
        end
        check("gap.total", obs_cnt(), 16'd2);

        // Counter saturation at 3, then clear beating a same-cycle match.
        select(1, "sat");
        bits(16'b111111, 6, "sat");
        check("sat.total", obs_cnt(), 16'd3);
        step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, "sat.clr");
        check("sat.cleared", obs_cnt(), 16'd0);

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            select(d, "rnd");
            for (int n = 0; n < 400; n++) begin
                step(($urandom % 4) != 0,
                     (d == 1) ? (($urandom % 4) != 0) : 1'($urandom),
                     ($urandom % 40) == 0,
                     8'($urandom),
                     1'($urandom),
                     ($urandom % 60) == 0,
                     "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
